// File: rtl/motor_spi_pkg.sv
// Shared definitions for the motor SPI frame scheduler.
// Holds the scheduler state encoding, the default timing constants and a
// small helper that turns a requested round period into the terminal value
// of the period counter.
package motor_spi_pkg;

  // Scheduler FSM states, in the order a normal frame walks through them.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    SELECT,
    START,
    WAIT_ACTIVE,
    WAIT_DONE,
    RELEASE,
    NEXT
  } sched_state_t;

  localparam int DEFAULT_NUM_MOTORS = 6;
  localparam int DEFAULT_SS_SETUP   = 4;
  localparam int DEFAULT_SS_HOLD    = 4;
  localparam int DEFAULT_TIMEOUT    = 4096;

  // Periods of 0 and 1 both mean "a round every cycle", so both map to a
  // terminal count of 0.
  function automatic logic [31:0] period_last(input logic [31:0] period);
    return (period < 32'd2) ? 32'd0 : period - 32'd1;
  endfunction

endpackage

// File: rtl/mask_priority_next.sv
// Next-motor selector for the frame scheduler.
// Returns the lowest set bit of mask strictly above cur_index, or the lowest
// set bit overall when from_start is high (used at the start of a round).
// Ports:
//   mask        round mask, bit i selects motor i
//   cur_index   index of the motor just serviced
//   from_start  search from index 0 inclusive instead of above cur_index
//   next_index  selected motor index (0 when none_left)
//   none_left   no eligible motor remains
module mask_priority_next
  import motor_spi_pkg::*;
#(
  parameter int NUM_MOTORS = DEFAULT_NUM_MOTORS
) (
  input  logic [NUM_MOTORS-1:0] mask,
  input  logic [7:0]            cur_index,
  input  logic                  from_start,
  output logic [7:0]            next_index,
  output logic                  none_left
);

  // Scan from the top down so the lowest eligible index is the one that
  // survives, giving ascending service order.
  always_comb begin
    next_index = '0;
    none_left  = 1'b1;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur_index)))) begin
        next_index = 8'(i);
        none_left  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/motor_frame_scheduler.sv
// Round-robin scheduler sharing one SPI frame engine between several motor
// boards. Every update_period cycles a round starts: the motor mask is
// latched, and each selected motor in ascending order gets its slave select
// driven low, a frame_start pulse, a wait for the engine to finish (with a
// timeout), and a hold time before the select is released.
// Ports:
//   clock, reset_n   system clock, synchronous active-low reset
//   enable           scheduler runs rounds while high
//   motor_mask       motors to include in the next round
//   update_period    cycles between consecutive round starts
//   frame_active     frame engine busy flag
//   error_clear      pulse clearing error_flags and overrun
//   frame_start      pulse starting one engine frame
//   ss_n             active-low slave selects, at most one low
//   motor_index      currently selected motor
//   round_done       pulse at the end of each round
//   error_flags      sticky per-motor timeout flags
//   overrun          sticky, a round outlasted its period
//   busy             high while a round is in progress
module motor_frame_scheduler
  import motor_spi_pkg::*;
#(
  parameter int NUM_MOTORS = DEFAULT_NUM_MOTORS,
  parameter int SS_SETUP   = DEFAULT_SS_SETUP,
  parameter int SS_HOLD    = DEFAULT_SS_HOLD,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_MOTORS-1:0] motor_mask,
  input  logic [31:0]           update_period,
  input  logic                  frame_active,
  input  logic                  error_clear,
  output logic                  frame_start,
  output logic [NUM_MOTORS-1:0] ss_n,
  output logic [7:0]            motor_index,
  output logic                  round_done,
  output logic [NUM_MOTORS-1:0] error_flags,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [31:0] SETUP_LAST   = 32'(SS_SETUP - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(SS_HOLD - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  sched_state_t          state;
  logic [31:0]           period_cnt;
  logic [31:0]           phase_cnt;
  logic                  kickoff;
  logic                  late_start;
  logic [NUM_MOTORS-1:0] round_mask;

  logic [NUM_MOTORS-1:0] search_mask;
  logic                  from_start;
  logic [7:0]            next_index;
  logic                  none_left;
  logic                  in_round;
  logic                  period_tick;
  logic                  round_start;
  logic                  timeout_hit;
  logic [NUM_MOTORS-1:0] cur_onehot;
  logic [NUM_MOTORS-1:0] next_onehot;

  assign in_round    = (state != IDLE) && (state != WAIT_PERIOD);
  assign period_tick = (state != IDLE) && (period_cnt == period_last(update_period));

  // A round begins on a period boundary, on the first cycle after leaving
  // IDLE (kickoff), or right after a round that overran its boundary.
  assign round_start = (state == WAIT_PERIOD) && enable &&
                       (kickoff || late_start || period_tick);

  assign timeout_hit = (((state == WAIT_ACTIVE) && !frame_active) ||
                        ((state == WAIT_DONE) && frame_active)) &&
                       (phase_cnt == TIMEOUT_LAST);

  // At round start the live mask is searched from index 0; inside a round
  // the latched mask is searched above the motor just serviced.
  assign search_mask = (state == WAIT_PERIOD) ? motor_mask : round_mask;
  assign from_start  = (state == WAIT_PERIOD);
  assign cur_onehot  = NUM_MOTORS'(1) << motor_index;
  assign next_onehot = NUM_MOTORS'(1) << next_index;

  mask_priority_next #(
    .NUM_MOTORS (NUM_MOTORS)
  ) u_next (
    .mask       (search_mask),
    .cur_index  (motor_index),
    .from_start (from_start),
    .next_index (next_index),
    .none_left  (none_left)
  );

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      period_cnt  <= '0;
      phase_cnt   <= '0;
      kickoff     <= 1'b0;
      late_start  <= 1'b0;
      round_mask  <= '0;
      frame_start <= 1'b0;
      ss_n        <= '1;
      motor_index <= '0;
      round_done  <= 1'b0;
      error_flags <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      round_done  <= 1'b0;

      // The kickoff start re-zeroes the counter so the second round starts
      // a full period after the first.
      if (state == IDLE) begin
        period_cnt <= '0;
      end else if (period_tick || (round_start && kickoff)) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 32'd1;
      end

      // A boundary missed while busy is remembered so the next round starts
      // as soon as the current one finishes.
      if (period_tick && in_round) begin
        overrun    <= 1'b1;
        late_start <= 1'b1;
      end else if (error_clear) begin
        overrun <= 1'b0;
      end

      // A timeout in the same cycle as error_clear still leaves its flag set.
      error_flags <= (error_clear ? '0 : error_flags) |
                     (timeout_hit ? cur_onehot : '0);

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= WAIT_PERIOD;
            kickoff <= 1'b1;
          end
        end

        WAIT_PERIOD: begin
          if (!enable) begin
            state      <= IDLE;
            kickoff    <= 1'b0;
            late_start <= 1'b0;
          end else if (round_start) begin
            kickoff    <= 1'b0;
            late_start <= 1'b0;
            round_mask <= motor_mask;
            if (none_left) begin
              round_done <= 1'b1;
            end else begin
              state       <= SELECT;
              motor_index <= next_index;
              ss_n        <= ~next_onehot;
              phase_cnt   <= '0;
              busy        <= 1'b1;
            end
          end
        end

        SELECT: begin
          if (phase_cnt == SETUP_LAST) begin
            state       <= START;
            frame_start <= 1'b1;
            phase_cnt   <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        START: begin
          state     <= WAIT_ACTIVE;
          phase_cnt <= '0;
        end

        WAIT_ACTIVE: begin
          if (frame_active) begin
            state     <= WAIT_DONE;
            phase_cnt <= '0;
          end else if (timeout_hit) begin
            state     <= RELEASE;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        WAIT_DONE: begin
          if (!frame_active || timeout_hit) begin
            state     <= RELEASE;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        RELEASE: begin
          if (phase_cnt == HOLD_LAST) begin
            state     <= NEXT;
            ss_n      <= '1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        NEXT: begin
          // Dropping enable skips the remaining motors and ends in IDLE.
          if (!enable || none_left) begin
            round_done <= 1'b1;
            busy       <= 1'b0;
            if (enable) begin
              state <= WAIT_PERIOD;
            end else begin
              state      <= IDLE;
              kickoff    <= 1'b0;
              late_start <= 1'b0;
            end
          end else begin
            state       <= SELECT;
            motor_index <= next_index;
            ss_n        <= ~next_onehot;
            phase_cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_frame_scheduler.sv
// Directed testbench for motor_frame_scheduler with default parameters.
// A frame-engine model answers frame_start by holding frame_active high for
// active_len cycles (or never, in timeout tests); a monitor logs frames,
// round_done pulses and slave-select activity for the checks.
module tb_motor_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [5:0]  motor_mask;
  logic [31:0] update_period;
  logic        frame_active = 1'b0;
  logic        error_clear;
  logic        frame_start;
  logic [5:0]  ss_n;
  logic [7:0]  motor_index;
  logic        round_done;
  logic [5:0]  error_flags;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int engine_mode = 0;
  int active_len  = 300;
  int eng_cnt     = 0;

  int   cycle       = 0;
  int   fs_count    = 0;
  int   rd_count    = 0;
  int   rd_last     = 0;
  int   rd_prev     = 0;
  int   multi_sel   = 0;
  int   ss_low_run  = 0;
  int   setup_len   = 0;
  int   fs_cycle    = 0;
  int   rel_delay   = 0;
  bit   pending_rel = 1'b0;
  logic [5:0] fs_ss = 6'h3F;
  int   fs_idx[$];
  int   sel_seen[6] = '{0, 0, 0, 0, 0, 0};

  motor_frame_scheduler dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .motor_mask    (motor_mask),
    .update_period (update_period),
    .frame_active  (frame_active),
    .error_clear   (error_clear),
    .frame_start   (frame_start),
    .ss_n          (ss_n),
    .motor_index   (motor_index),
    .round_done    (round_done),
    .error_flags   (error_flags),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Frame engine model: busy for active_len cycles after each frame_start.
  always @(negedge clock) begin
    if (!reset_n) begin
      frame_active = 1'b0;
      eng_cnt      = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) frame_active = 1'b0;
    end else if (frame_start && engine_mode == 0) begin
      frame_active = 1'b1;
      eng_cnt      = active_len;
    end
  end

  // Monitor sampling shortly after each rising edge.
  always begin
    @(posedge clock);
    #1;
    cycle = cycle + 1;
    if (frame_start) begin
      fs_count = fs_count + 1;
      fs_idx.push_back(int'(motor_index));
      fs_cycle    = cycle;
      setup_len   = ss_low_run;
      fs_ss       = ss_n;
      pending_rel = 1'b1;
    end
    if (ss_n != 6'h3F) begin
      ss_low_run = ss_low_run + 1;
    end else begin
      if (pending_rel) begin
        rel_delay   = cycle - fs_cycle;
        pending_rel = 1'b0;
      end
      ss_low_run = 0;
    end
    if (round_done) begin
      rd_count = rd_count + 1;
      rd_prev  = rd_last;
      rd_last  = cycle;
    end
    if ($countones(~ss_n) > 1) multi_sel = multi_sel + 1;
    for (int i = 0; i < 6; i++) begin
      if (!ss_n[i]) sel_seen[i] = sel_seen[i] + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] mask,
                               input logic [31:0] period);
    enable        = en;
    motor_mask    = mask;
    update_period = period;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n     = 1'b0;
    enable      = 1'b0;
    error_clear = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic waitFrames(input int target, input int budget, input string tag);
    int n = 0;
    while (fs_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(fs_count >= target), 32'd1);
  endtask

  task automatic waitRounds(input int target, input int budget, input string tag);
    int n = 0;
    while (rd_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(rd_count >= target), 32'd1);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  function automatic int fsAt(input int k);
    return (k < fs_idx.size()) ? fs_idx[k] : -1;
  endfunction

  initial begin
    int base;
    int fbase;
    int rbase;
    int qbase;
    int sel_other;
    int sel2;

    reset_n       = 1'b0;
    enable        = 1'b0;
    motor_mask    = '0;
    update_period = '0;
    error_clear   = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values
    checkOutput("rst_ss_n",        32'(ss_n),        32'h3F);
    checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
    checkOutput("rst_motor_index", 32'(motor_index), 32'd0);
    checkOutput("rst_round_done",  32'(round_done),  32'd0);
    checkOutput("rst_error_flags", 32'(error_flags), 32'd0);
    checkOutput("rst_overrun",     32'(overrun),     32'd0);
    checkOutput("rst_busy",        32'(busy),        32'd0);
    reset_n = 1'b1;

    // Empty mask: period 0 behaves as 1, so round_done pulses every cycle
    @(negedge clock);
    applyStimulus(1'b1, 6'b000000, 32'd0);
    repeat (5) @(negedge clock);
    base  = rd_count;
    fbase = fs_count;
    repeat (10) @(negedge clock);
    checkOutput("empty_p0_rounds", rd_count - base, 32'd10);
    checkOutput("empty_p0_frames", fs_count - fbase, 32'd0);
    checkOutput("empty_p0_busy",   32'(busy), 32'd0);
    update_period = 32'd1;
    repeat (2) @(negedge clock);
    base = rd_count;
    repeat (10) @(negedge clock);
    checkOutput("empty_p1_rounds", rd_count - base, 32'd10);
    update_period = 32'd10;
    waitRounds(rd_count + 3, 60, "empty_p10_wait");
    checkOutput("empty_p10_interval", rd_last - rd_prev, 32'd10);
    doReset();

    // Two motors, long period: frames 0 then 2, regular round spacing
    engine_mode = 0;
    active_len  = 300;
    qbase     = fs_idx.size();
    sel_other = sel_seen[1] + sel_seen[3] + sel_seen[4] + sel_seen[5];
    @(negedge clock);
    applyStimulus(1'b1, 6'b000101, 32'd2000);
    waitRounds(rd_count + 3, 8000, "r41_rounds_wait");
    checkOutput("r41_frame0", fsAt(qbase),     32'd0);
    checkOutput("r41_frame1", fsAt(qbase + 1), 32'd2);
    checkOutput("r41_frame2", fsAt(qbase + 2), 32'd0);
    checkOutput("r41_frame3", fsAt(qbase + 3), 32'd2);
    checkOutput("r41_round_interval", rd_last - rd_prev, 32'd2000);
    checkOutput("r41_setup_len", setup_len, 32'd4);
    checkOutput("r41_release_delay", rel_delay, 32'd305);
    checkOutput("r41_unselected",
                sel_seen[1] + sel_seen[3] + sel_seen[4] + sel_seen[5] - sel_other,
                32'd0);
    checkOutput("r41_overrun", 32'(overrun), 32'd0);
    checkOutput("r41_errors",  32'(error_flags), 32'd0);
    doReset();

    // Engine never responds: timeout on motor 1
    engine_mode = 1;
    fbase = fs_count;
    @(negedge clock);
    applyStimulus(1'b1, 6'b000010, 32'd10000);
    waitFrames(fbase + 1, 100, "r42_frame_wait");
    checkOutput("r42_index",        32'(motor_index), 32'd1);
    checkOutput("r42_flags_before", 32'(error_flags), 32'd0);
    checkOutput("r42_ss_at_start",  32'(fs_ss), 32'h3D);
    waitRounds(rd_count + 1, 5000, "r42_round_wait");
    checkOutput("r42_flags_after",   32'(error_flags), 32'h02);
    checkOutput("r42_release_delay", rel_delay, 32'd4101);
    checkOutput("r42_ss_released",   32'(ss_n), 32'h3F);
    error_clear = 1'b1;
    @(negedge clock);
    error_clear = 1'b0;
    checkOutput("r42_flags_cleared", 32'(error_flags), 32'd0);
    engine_mode = 0;
    doReset();

    // Three motors exceed a 500 cycle period: overrun and back-to-back rounds
    @(negedge clock);
    applyStimulus(1'b1, 6'b000111, 32'd500);
    waitRounds(rd_count + 1, 2000, "r43_round_wait");
    checkOutput("r43_overrun", 32'(overrun), 32'd1);
    @(negedge clock);
    checkOutput("r43_next_ss",   32'(ss_n), 32'h3E);
    checkOutput("r43_next_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    waitIdle(2000, "r43_idle_wait");
    error_clear = 1'b1;
    @(negedge clock);
    error_clear = 1'b0;
    checkOutput("r43_overrun_cleared", 32'(overrun), 32'd0);
    doReset();

    // enable dropped during motor 1's frame
    fbase = fs_count;
    sel2  = sel_seen[2];
    @(negedge clock);
    applyStimulus(1'b1, 6'b000111, 32'd5000);
    waitFrames(fbase + 2, 1000, "r44_frame_wait");
    checkOutput("r44_index", 32'(motor_index), 32'd1);
    repeat (50) @(negedge clock);
    enable = 1'b0;
    rbase  = rd_count;
    waitRounds(rbase + 1, 1000, "r44_round_wait");
    checkOutput("r44_release_delay", rel_delay, 32'd305);
    @(negedge clock);
    checkOutput("r44_busy", 32'(busy), 32'd0);
    repeat (100) @(negedge clock);
    checkOutput("r44_motor2_unselected", sel_seen[2] - sel2, 32'd0);
    checkOutput("r44_frames", fs_count - fbase, 32'd2);
    checkOutput("r44_rounds", rd_count - rbase, 32'd1);
    doReset();

    // Mask change mid-round takes effect in the next round
    fbase = fs_count;
    @(negedge clock);
    applyStimulus(1'b1, 6'b000001, 32'd3000);
    waitFrames(fbase + 1, 100, "r45_frame_wait");
    checkOutput("r45_first_index", 32'(motor_index), 32'd0);
    motor_mask = 6'b100000;
    waitRounds(rd_count + 1, 1000, "r45_round_wait");
    checkOutput("r45_round1_frames", fs_count - fbase, 32'd1);
    waitFrames(fbase + 2, 4000, "r45_frame2_wait");
    checkOutput("r45_second_index", 32'(motor_index), 32'd5);
    checkOutput("r45_second_ss",    32'(fs_ss), 32'h1F);
    doReset();

    // Reset during WAIT_DONE releases selects immediately
    fbase = fs_count;
    @(negedge clock);
    applyStimulus(1'b1, 6'b000001, 32'd3000);
    waitFrames(fbase + 1, 100, "r46_frame_wait");
    repeat (20) @(negedge clock);
    checkOutput("r46_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    enable  = 1'b0;
    @(negedge clock);
    checkOutput("r46_ss_after_reset",    32'(ss_n), 32'h3F);
    checkOutput("r46_busy_after_reset",  32'(busy), 32'd0);
    checkOutput("r46_index_after_reset", 32'(motor_index), 32'd0);
    reset_n = 1'b1;
    repeat (200) @(negedge clock);
    checkOutput("r46_no_frame", fs_count - fbase, 32'd1);
    enable = 1'b1;
    waitFrames(fbase + 2, 100, "r46_restart_wait");

    checkOutput("single_select", multi_sel, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_frame_scheduler.md
MOTOR_FRAME_SCHEDULER -- requirements
Module: motor_frame_scheduler

Interface
REQ-001 Parameter NUM_MOTORS, default 6, number of motor boards sharing one SPI frame engine.
REQ-002 Parameter SS_SETUP, default 4, cycles slave-select is held low before frame start.
REQ-003 Parameter SS_HOLD, default 4, cycles slave-select stays low after the frame ends.
REQ-004 Parameter TIMEOUT, default 4096, maximum cycles allowed for each frame-engine wait phase.
REQ-005 Port clock  in  1  system clock; all logic on its rising edge.
REQ-006 Port reset_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-007 Port enable  in  1  level; scheduler runs rounds while high.
REQ-008 Port motor_mask  in  NUM_MOTORS  bit i=1 includes motor i in a round.
REQ-009 Port update_period  in  32  cycles between consecutive round starts.
REQ-010 Port frame_active  in  1  frame-engine busy flag; high while a 12-word frame runs.
REQ-011 Port error_clear  in  1  single-cycle pulse; clears error_flags and overrun.
REQ-012 Port frame_start  out  1  single-cycle pulse; starts one frame-engine frame.
REQ-013 Port ss_n  out  NUM_MOTORS  active-low slave selects; at most one bit low.
REQ-014 Port motor_index  out  8  index of the currently selected motor.
REQ-015 Port round_done  out  1  single-cycle pulse at the end of each round.
REQ-016 Port error_flags  out  NUM_MOTORS  sticky per-motor timeout flags.
REQ-017 Port overrun  out  1  sticky; a round outlasted update_period.
REQ-018 Port busy  out  1  high in every state except IDLE and WAIT_PERIOD.

Function
REQ-019 FSM states: IDLE, WAIT_PERIOD, SELECT, START, WAIT_ACTIVE, WAIT_DONE, RELEASE, NEXT.
REQ-020 IDLE -> WAIT_PERIOD when enable=1; period counter loads 0, so the first round begins on the next cycle.
REQ-021 Period counter free-runs in every non-IDLE state; reaching update_period-1 triggers a round start and reloads it to 0.
REQ-022 Round start latches motor_mask into a round mask; mask changes mid-round have no effect until the next round.
REQ-023 Motors are visited in ascending index order, and only those with a latched bit set.
REQ-024 Empty latched mask: no frames run and round_done pulses at the period boundary.
REQ-025 SELECT: drive ss_n[i] low and update motor_index; after SS_SETUP cycles, go to START.
REQ-026 START: assert frame_start for exactly one cycle, then go to WAIT_ACTIVE.
REQ-027 WAIT_ACTIVE -> WAIT_DONE on frame_active=1.
REQ-028 WAIT_DONE -> RELEASE on frame_active=0.
REQ-029 If WAIT_ACTIVE or WAIT_DONE lasts TIMEOUT cycles: set error_flags[i] and go to RELEASE.
REQ-030 RELEASE: hold ss_n low for SS_HOLD cycles, then drive all ss_n high and go to NEXT.
REQ-031 NEXT: go to SELECT for the next masked motor; if none remain, pulse round_done and go to WAIT_PERIOD.
REQ-032 Period boundary reached while busy: set overrun; the next round starts in the cycle after round_done.
REQ-033 enable falling mid-round: the current frame and its RELEASE complete, remaining motors are skipped, round_done pulses, then IDLE.
REQ-034 enable falling in WAIT_PERIOD: go to IDLE next cycle.
REQ-035 error_clear coinciding with a new timeout: the new flag is set (set wins).
REQ-036 update_period values 0 and 1 are both treated as 1.

Reset
REQ-037 While reset_n=0 at a clock edge, the FSM enters IDLE and outputs take: ss_n all ones, frame_start 0, motor_index 0, round_done 0, error_flags 0, overrun 0, busy 0; all counters clear.
REQ-038 Reset asserted mid-frame releases ss_n on the next clock edge, without waiting for SS_HOLD.

Structure
REQ-039 The FSM state enumeration and default SS_SETUP/SS_HOLD/TIMEOUT constants live in a shared package, motor_spi_pkg.
REQ-040 Next-motor selection is a sub-module, mask_priority_next: given the round mask and current index, it returns the next set index above the current one plus a none-left flag.

Verification
REQ-041 Mask 6'b000101, period 2000, engine model active for 300 cycles -> frames for motors 0 then 2; ss_n[0] low 4 cycles before frame_start; one round_done per 2000 cycles.
REQ-042 Engine model never raises active, mask 6'b000010 -> error_flags=6'b000010 after 4096 cycles in WAIT_ACTIVE; ss_n released after SS_HOLD; round_done pulses.
REQ-043 Period 500 with three motors at 300 cycles each -> overrun=1; next round starts the cycle after round_done; error_clear then gives overrun=0.
REQ-044 enable dropped during motor 1's frame, mask 6'b000111 -> motor 1 completes, motor 2 is never selected, round_done pulses, busy=0 afterwards.
REQ-045 Mask changed from 6'b000001 to 6'b100000 mid-round -> current round unaffected; motor 5 is serviced in the next round.
REQ-046 reset_n low in WAIT_DONE -> ss_n=all ones and state IDLE on the next edge; no frame_start pulse until enable is reasserted.
